// File: rtl/gate_resp_if.sv
// Response channel for the gate checker: one (a, b, z) triple per transfer.
// Handshake: a triple transfers on a rising clk edge where valid && ready are
// both high. The master holds a/b/z stable while valid is high and ready is
// low. ready never depends combinationally on valid, and valid without ready
// transfers nothing.
interface gate_resp_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] z;

  modport master (output valid, output a, output b, output z, input ready);
  modport slave  (input valid, input a, input b, input z, output ready);
endinterface

// File: rtl/gate_response_checker_8b.sv
// Receiving end of the gate stimulus flow: checks each z against op(a, b),
// counts mismatches, records the first failing vector index and compacts
// every z into a MISR signature. A run accepts exactly NUM_VECTORS triples.
module gate_response_checker_8b #(
  parameter int               WIDTH       = 8,
  parameter int               NUM_VECTORS = 4,
  parameter logic [WIDTH-1:0] SIG_SEED    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  gate_resp_if.slave       resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       mismatch_count,
  output logic [7:0]       first_fail_idx,
  output logic             first_fail_valid,
  output logic [7:0]       vec_count,
  output logic [WIDTH-1:0] signature,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [7:0] NUM_V8 = 8'(NUM_VECTORS);

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       mm_q, mm_d;
  logic [7:0]       ffi_q, ffi_d;
  logic             ffv_q, ffv_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic             pass_q, pass_d;

  logic             accept;
  logic             mism;
  logic             fb;
  logic [WIDTH-1:0] exp_z;

  // Next-state and datapath updates; everything defaults to holding its value.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    mm_d    = mm_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    accept  = 1'b0;
    mism    = 1'b0;
    fb      = sig_q[WIDTH-1] ^ sig_q[WIDTH-3] ^ sig_q[WIDTH-4] ^ sig_q[WIDTH-5];
    case (op_q)
      2'b00:   exp_z = resp.a & resp.b;
      2'b01:   exp_z = resp.a | resp.b;
      2'b10:   exp_z = resp.a ^ resp.b;
      default: exp_z = ~(resp.a ^ resp.b);
    endcase

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          op_d    = op;
          cnt_d   = 8'd0;
          mm_d    = 8'd0;
          ffi_d   = 8'd0;
          ffv_d   = 1'b0;
          sig_d   = SIG_SEED;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        // ready equals (state == RUN), so valid alone qualifies the accept here
        accept = resp.valid;
        if (accept) begin
          mism = (resp.z != exp_z);
          if (mism) begin
            if (mm_q != 8'hFF) mm_d = mm_q + 8'd1;
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = cnt_q;
            end
          end
          cnt_d = cnt_q + 8'd1;
          sig_d = {sig_q[WIDTH-2:0], fb} ^ resp.z;
          if (cnt_d == NUM_V8) begin
            state_d = ST_DONE;
            pass_d  = (mm_d == 8'd0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      cnt_q   <= 8'd0;
      mm_q    <= 8'd0;
      ffi_q   <= 8'd0;
      ffv_q   <= 1'b0;
      sig_q   <= SIG_SEED;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      mm_q    <= mm_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  assign resp.ready       = (state_q == ST_RUN);
  assign busy             = (state_q == ST_RUN);
  assign done             = (state_q == ST_DONE);
  assign pass             = pass_q;
  assign mismatch_count   = mm_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;
  assign vec_count        = cnt_q;
  assign signature        = sig_q;
  assign fsm_state        = state_q;

endmodule
